// File: rtl/ysyx_22041211_mem_arbiter.sv
// Two-master (IFU/LSU) arbiter onto one memory port, round-robin on contention, response watchdog.
// Latency: grant in the accept cycle, mem_req_valid the next cycle, response routed combinationally.
// Backpressure: one transaction in flight; both *_req_ready low until the response or a timeout returns to IDLE.
module ysyx_22041211_mem_arbiter #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_LEN-1:0] ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_LEN-1:0] ifu_rdata,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic                lsu_wen,
    input  logic [ADDR_LEN-1:0] lsu_addr,
    input  logic [DATA_LEN-1:0] lsu_wdata,
    input  logic [7:0]          lsu_wmask,
    input  logic [7:0]          lsu_rmask,
    output logic                lsu_resp_valid,
    output logic [DATA_LEN-1:0] lsu_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_wen,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [DATA_LEN-1:0] mem_wdata,
    output logic [7:0]          mem_wmask,
    output logic [7:0]          mem_rmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_LEN-1:0] mem_rdata,
    output logic                timeout_err
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    state_t     state, state_nxt;
    logic       owner;
    logic       last_grant;
    logic [7:0] tmo_cnt;
    logic       resp_take;
    logic       abort;
    logic       accept;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Grant, next-state and response routing; the requester not granted last time wins a tie.
    always_comb begin
        state_nxt      = state;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        ifu_rdata      = '0;
        lsu_rdata      = '0;
        resp_take      = (state == RESP) && mem_resp_valid;
        abort          = (state != IDLE) && !resp_take && (tmo_cnt == 8'(TIMEOUT - 1));
        accept         = 1'b0;
        case (state)
            IDLE: begin
                ifu_req_ready = ifu_req_valid && (!lsu_req_valid || last_grant == OWN_LSU);
                lsu_req_ready = lsu_req_valid && (!ifu_req_valid || last_grant == OWN_IFU);
                accept        = ifu_req_ready || lsu_req_ready;
                if (accept) state_nxt = REQ;
            end
            REQ: begin
                if (abort)              state_nxt = IDLE;
                else if (mem_req_ready) state_nxt = RESP;
            end
            RESP: begin
                if (resp_take || abort) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (resp_take) begin
            ifu_resp_valid = (owner == OWN_IFU);
            lsu_resp_valid = (owner == OWN_LSU);
            ifu_rdata      = (owner == OWN_IFU) ? mem_rdata : '0;
            lsu_rdata      = (owner == OWN_LSU) ? mem_rdata : '0;
        end
    end

    // Watchdog: counts cycles spent away from IDLE, cleared whenever the FSM goes back to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    tmo_cnt <= 8'd0;
        else if (state_nxt == IDLE) tmo_cnt <= 8'd0;
        else if (state != IDLE)     tmo_cnt <= tmo_cnt + 8'd1;
    end

    // Sticky error flag; the aborted owner gets no response and must retry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        timeout_err <= 1'b0;
        else if (abort) timeout_err <= 1'b1;
    end

    // Memory request valid: raised on grant, dropped once memory takes it or the watchdog fires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                            mem_req_valid <= 1'b0;
        else if (accept)                                    mem_req_valid <= 1'b1;
        else if (state == REQ && (mem_req_ready || abort))  mem_req_valid <= 1'b0;
    end

    // Latch the winner's payload and ownership; instruction fetches are always full-word reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wen    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wmask  <= 8'h00;
            mem_rmask  <= 8'h00;
            owner      <= OWN_IFU;
            last_grant <= OWN_IFU;
        end else if (ifu_req_ready) begin
            mem_wen    <= 1'b0;
            mem_addr   <= ifu_addr;
            mem_wdata  <= '0;
            mem_wmask  <= 8'h00;
            mem_rmask  <= 8'h0F;
            owner      <= OWN_IFU;
            last_grant <= OWN_IFU;
        end else if (lsu_req_ready) begin
            mem_wen    <= lsu_wen;
            mem_addr   <= lsu_addr;
            mem_wdata  <= lsu_wdata;
            mem_wmask  <= lsu_wmask;
            mem_rmask  <= lsu_rmask;
            owner      <= OWN_LSU;
            last_grant <= OWN_LSU;
        end
    end

endmodule

// File: tb/tb_ysyx_22041211_mem_arbiter.sv
// Bench for ysyx_22041211_mem_arbiter: transaction-level model checked every cycle plus directed literals.
// Latency: inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: mem_req_ready / mem_resp_valid driven directly by the stimulus.
module tb_ysyx_22041211_mem_arbiter;

    localparam int TMO = 8;

    logic        clk, rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_wmask, lsu_rmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask, mem_rmask;
    logic        timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    ysyx_22041211_mem_arbiter #(.ADDR_LEN(32), .DATA_LEN(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_rmask(lsu_rmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rmask(mem_rmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: one outstanding transfer, its age, whether memory took it.
    bit          m_busy, m_sent, m_owner, m_last, m_err, m_wen;
    int          m_age;
    logic [31:0] m_addr, m_wdata;
    logic [7:0]  m_wmask, m_rmask;

    function automatic bit win_ifu();
        return !m_busy && ifu_req_valid && (!lsu_req_valid || m_last);
    endfunction
    function automatic bit win_lsu();
        return !m_busy && lsu_req_valid && (!ifu_req_valid || !m_last);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_sent = 0; m_owner = 0; m_last = 0; m_err = 0; m_wen = 0; m_age = 0;
            m_addr = 0; m_wdata = 0; m_wmask = 0; m_rmask = 0;
        end else if (m_busy) begin
            if (m_sent && mem_resp_valid) m_busy = 0;
            else if (m_age + 1 == TMO) begin m_busy = 0; m_err = 1; end
            else begin
                m_age++;
                if (!m_sent && mem_req_ready) m_sent = 1;
            end
        end else if (win_ifu()) begin
            m_busy = 1; m_sent = 0; m_age = 0; m_owner = 0; m_last = 0;
            m_wen = 0; m_addr = ifu_addr; m_wdata = 0; m_wmask = 8'h00; m_rmask = 8'h0F;
        end else if (win_lsu()) begin
            m_busy = 1; m_sent = 0; m_age = 0; m_owner = 1; m_last = 1;
            m_wen = lsu_wen; m_addr = lsu_addr; m_wdata = lsu_wdata; m_wmask = lsu_wmask; m_rmask = lsu_rmask;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (!rst) begin
            bit e_ir, e_lr;
            e_ir = m_busy && m_sent && mem_resp_valid && !m_owner;
            e_lr = m_busy && m_sent && mem_resp_valid && m_owner;
            chk("m_req_valid", 32'(mem_req_valid), 32'(m_busy && !m_sent));
            chk("m_addr", mem_addr, m_addr);
            chk("m_wdata", mem_wdata, m_wdata);
            chk("m_wen", 32'(mem_wen), 32'(m_wen));
            chk("m_masks", {16'h0, mem_wmask, mem_rmask}, {16'h0, m_wmask, m_rmask});
            chk("m_ifu_ready", 32'(ifu_req_ready), 32'(win_ifu()));
            chk("m_lsu_ready", 32'(lsu_req_ready), 32'(win_lsu()));
            chk("m_ifu_resp", 32'(ifu_resp_valid), 32'(e_ir));
            chk("m_lsu_resp", 32'(lsu_resp_valid), 32'(e_lr));
            if (e_ir) chk("m_ifu_rdata", ifu_rdata, mem_rdata);
            if (e_lr) chk("m_lsu_rdata", lsu_rdata, mem_rdata);
            chk("m_timeout_err", 32'(timeout_err), 32'(m_err));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; ifu_req_valid = 0; ifu_addr = 0;
        lsu_req_valid = 0; lsu_wen = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wmask = 0; lsu_rmask = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;

        // Reset state.
        @(negedge clk);
        chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_payload", mem_addr | mem_wdata | {16'h0, mem_wmask, mem_rmask} | 32'(mem_wen), 32'd0);
        chk("rst_err", 32'(timeout_err), 32'd0);
        chk("rst_resp", 32'({ifu_resp_valid, lsu_resp_valid}), 32'd0);
        tick();
        rst = 0;

        // IFU only fetch.
        ifu_req_valid = 1; ifu_addr = 32'h8000_0000; mem_req_ready = 1;
        @(negedge clk);
        chk("ifu_ready", 32'(ifu_req_ready), 32'd1);
        chk("ifu_lsu_ready", 32'(lsu_req_ready), 32'd0);
        tick(); ifu_req_valid = 0;
        @(negedge clk);
        chk("ifu_mem_valid", 32'(mem_req_valid), 32'd1);
        chk("ifu_mem_addr", mem_addr, 32'h8000_0000);
        chk("ifu_mem_wen", 32'(mem_wen), 32'd0);
        chk("ifu_mem_rmask", 32'(mem_rmask), 32'h0F);
        tick(); mem_resp_valid = 1; mem_rdata = 32'h0000_0413;
        @(negedge clk);
        chk("ifu_resp", 32'(ifu_resp_valid), 32'd1);
        chk("ifu_rdata", ifu_rdata, 32'h0000_0413);
        chk("ifu_lsu_resp", 32'(lsu_resp_valid), 32'd0);
        tick(); mem_resp_valid = 0; mem_req_ready = 0;

        // LSU store under 5 cycles of memory backpressure.
        lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_1000; lsu_wdata = 32'hDEAD_BEEF;
        lsu_wmask = 8'h0F; lsu_rmask = 8'h00;
        @(negedge clk);
        chk("st_lsu_ready", 32'(lsu_req_ready), 32'd1);
        tick(); ifu_req_valid = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(mem_req_valid), 32'd1);
            chk("bp_wdata", mem_wdata, 32'hDEAD_BEEF);
            chk("bp_wen_wmask", {23'h0, mem_wen, mem_wmask}, {23'h0, 1'b1, 8'h0F});
            chk("bp_readies", 32'({ifu_req_ready, lsu_req_ready}), 32'd0);
            tick();
        end
        mem_req_ready = 1; ifu_req_valid = 0; lsu_req_valid = 0;
        tick(); mem_req_ready = 0; mem_resp_valid = 1;
        @(negedge clk);
        chk("st_resp", 32'(lsu_resp_valid), 32'd1);
        tick(); mem_resp_valid = 0;

        // Simultaneous requests after reset: LSU, IFU, LSU.
        rst = 1; tick(); rst = 0;
        ifu_req_valid = 1; ifu_addr = 32'h8000_0004;
        lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 32'h8000_3000; lsu_rmask = 8'hFF;
        mem_req_ready = 1; mem_resp_valid = 1; mem_rdata = 32'hA5A5_A5A5;
        @(negedge clk);
        chk("rr1_lsu", 32'({ifu_req_ready, lsu_req_ready}), 32'b01);
        tick();
        @(negedge clk);
        chk("rr1_no_resp_in_req", 32'(lsu_resp_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("rr1_resp", 32'({ifu_resp_valid, lsu_resp_valid}), 32'b01);
        chk("rr1_rdata", lsu_rdata, 32'hA5A5_A5A5);
        tick();
        @(negedge clk);
        chk("rr2_ifu", 32'({ifu_req_ready, lsu_req_ready}), 32'b10);
        tick(); tick();
        @(negedge clk);
        chk("rr2_resp", 32'(ifu_resp_valid), 32'd1);
        tick();
        @(negedge clk);
        chk("rr3_lsu", 32'({ifu_req_ready, lsu_req_ready}), 32'b01);
        tick(); ifu_req_valid = 0; lsu_req_valid = 0;
        tick(); tick(); mem_req_ready = 0; mem_resp_valid = 0;

        // Timeout with no response, then a retry that completes.
        ifu_req_valid = 1; ifu_addr = 32'h8000_0040;
        tick();
        for (int i = 1; i <= TMO; i++) begin
            if (i == 3) mem_req_ready = 1;
            @(negedge clk);
            chk("to_no_resp", 32'({ifu_resp_valid, lsu_resp_valid}), 32'd0);
            chk("to_no_ready", 32'(ifu_req_ready), 32'd0);
            if (i == TMO) chk("to_err_before", 32'(timeout_err), 32'd0);
            tick();
        end
        @(negedge clk);
        chk("to_err_set", 32'(timeout_err), 32'd1);
        chk("to_idle_regrant", 32'(ifu_req_ready), 32'd1);
        chk("to_req_dropped", 32'(mem_req_valid), 32'd0);
        tick(); ifu_req_valid = 0;
        @(negedge clk);
        chk("retry_addr", mem_addr, 32'h8000_0040);
        tick(); mem_resp_valid = 1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("retry_resp", 32'(ifu_resp_valid), 32'd1);
        chk("retry_rdata", ifu_rdata, 32'h1234_5678);
        chk("retry_err_sticky", 32'(timeout_err), 32'd1);
        tick(); mem_resp_valid = 0;

        // Asynchronous reset while waiting in RESP.
        lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 32'h8000_2000; lsu_rmask = 8'h0F;
        tick(); lsu_req_valid = 0;
        @(negedge clk);
        chk("ar_req_valid", 32'(mem_req_valid), 32'd1);
        tick();
        #2 rst = 1;
        #1;
        chk("ar_addr_cleared", mem_addr, 32'd0);
        chk("ar_err_cleared", 32'(timeout_err), 32'd0);
        chk("ar_rmask_cleared", 32'(mem_rmask), 32'd0);
        mem_resp_valid = 1;
        #1;
        chk("ar_no_resp", 32'(lsu_resp_valid), 32'd0);
        tick(); rst = 0;
        @(negedge clk);
        chk("ar_stray_resp", 32'({ifu_resp_valid, lsu_resp_valid}), 32'd0);
        tick(); tick(); mem_resp_valid = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
